// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the decode/execute pipeline slice:
//   - ALUOp encodings produced by the main decoder
//   - opcode constants used by the decoder and by later forwarding work
//   - ctrl_t: the packed control bundle carried from ID into EX
//   - gate_ctrl(): squashes a control bundle when its instruction is not real
// ----------------------------------------------------------------------------
package pipe_pkg;

   localparam logic [1:0] ALU_OP_R     = 2'b10;
   localparam logic [1:0] ALU_OP_MEMI  = 2'b01;
   localparam logic [1:0] ALU_OP_OTHER = 2'b00;

   localparam logic [5:0] OP_RTYPE = 6'b000100;
   localparam logic [5:0] OP_IMM0  = 6'b001100;
   localparam logic [5:0] OP_IMM1  = 6'b001101;
   localparam logic [5:0] OP_SW    = 6'b010000;
   localparam logic [5:0] OP_LW    = 6'b010001;

   typedef struct packed {
      logic [1:0] alu_op;
      logic       reg_write;
      logic       mem_write;
      logic       mem_read;
   } ctrl_t;

   // All-zero bundle: what a bubble or a killed instruction carries.
   localparam ctrl_t CTRL_NONE = '{alu_op:    ALU_OP_OTHER,
                                   reg_write: 1'b0,
                                   mem_write: 1'b0,
                                   mem_read:  1'b0};

   // Pass the bundle through only when the instruction is valid, so that no
   // side-effecting control bit can ever travel without a valid instruction.
   function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic valid);
      ctrl_t r;
      if (valid) begin
         r = c;
      end else begin
         r = CTRL_NONE;
      end
      return r;
   endfunction

endpackage : pipe_pkg

// File: rtl/id_ex_stage_hazard_unit.sv
// ----------------------------------------------------------------------------
// hazard_unit
// Purely combinational load-use hazard detector.
// Ports:
//   id_valid, id_alu_op, id_mem_write, id_rs, id_rt : instruction in decode
//   ex_valid, ex_mem_read, ex_dst                    : instruction in EX
//   uses_rt : decode instruction reads rt as a source (R-type or store)
//   hazard  : decode instruction needs the result of the load sitting in EX
// ----------------------------------------------------------------------------
module hazard_unit
   import pipe_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic             id_valid,
   input  logic [1:0]       id_alu_op,
   input  logic             id_mem_write,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             ex_valid,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_dst,
   output logic             hazard,
   output logic             uses_rt
);

   // Source-use decode and load-use compare. Register 0 is hard-wired to zero,
   // so a load targeting it can never create a real dependency.
   always_comb begin
      uses_rt = (id_alu_op == ALU_OP_R) | id_mem_write;
      if (id_valid && ex_valid && ex_mem_read && (ex_dst != {REG_W{1'b0}})) begin
         hazard = (ex_dst == id_rs) | (uses_rt & (ex_dst == id_rt));
      end else begin
         hazard = 1'b0;
      end
   end

endmodule : hazard_unit

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with load-use stall, branch flush, EX back-pressure
// and a saturating bubble counter.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   id_*                : decoded instruction presented by decode
//   flush               : kill the instruction entering EX
//   ex_ready            : EX accepts a new instruction this cycle
//   id_stall            : combinational; decode/IF hold their registers
//   ex_*                : registered instruction presented to EX
//   bubble_count        : load-use bubbles inserted since reset (saturating)
// ----------------------------------------------------------------------------
module id_ex_stage
   import pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [1:0]        id_alu_op,
   input  logic              id_reg_write,
   input  logic              id_mem_write,
   input  logic              id_mem_read,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic [REG_W-1:0]  id_rd,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [5:0]        id_funct,
   input  logic              flush,
   input  logic              ex_ready,
   output logic              id_stall,
   output logic              ex_valid,
   output logic [1:0]        ex_alu_op,
   output logic              ex_reg_write,
   output logic              ex_mem_write,
   output logic              ex_mem_read,
   output logic              ex_alu_src,
   output logic [REG_W-1:0]  ex_dst,
   output logic [REG_W-1:0]  ex_rs,
   output logic [REG_W-1:0]  ex_rt,
   output logic [DATA_W-1:0] ex_rs_data,
   output logic [DATA_W-1:0] ex_rt_data,
   output logic [DATA_W-1:0] ex_imm,
   output logic [5:0]        ex_funct,
   output logic [CNT_W-1:0]  bubble_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // ---- EX register state -------------------------------------------------
   logic              ex_valid_q,   ex_valid_d;
   ctrl_t             ex_ctrl_q,    ex_ctrl_d;
   logic              ex_alu_src_q, ex_alu_src_d;
   logic [REG_W-1:0]  ex_dst_q,     ex_dst_d;
   logic [REG_W-1:0]  ex_rs_q,      ex_rs_d;
   logic [REG_W-1:0]  ex_rt_q,      ex_rt_d;
   logic [DATA_W-1:0] ex_rs_data_q, ex_rs_data_d;
   logic [DATA_W-1:0] ex_rt_data_q, ex_rt_data_d;
   logic [DATA_W-1:0] ex_imm_q,     ex_imm_d;
   logic [5:0]        ex_funct_q,   ex_funct_d;
   logic [CNT_W-1:0]  bubble_count_q, bubble_count_d;

   // ---- decode-side derivations -------------------------------------------
   ctrl_t             id_ctrl_s;
   logic [REG_W-1:0]  id_dst_s;
   logic              id_alu_src_s;
   logic              hazard_s;
   logic              uses_rt_s;

   hazard_unit #(
      .REG_W (REG_W)
   ) u_hazard_unit (
      .id_valid     (id_valid),
      .id_alu_op    (id_alu_op),
      .id_mem_write (id_mem_write),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .ex_valid     (ex_valid_q),
      .ex_mem_read  (ex_ctrl_q.mem_read),
      .ex_dst       (ex_dst_q),
      .hazard       (hazard_s),
      .uses_rt      (uses_rt_s)
   );

   // Bundle the decode controls and pick destination / operand-B source.
   // R-type writes rd and uses rt as a register operand; everything else
   // writes rt and takes the immediate.
   always_comb begin
      id_ctrl_s.alu_op    = id_alu_op;
      id_ctrl_s.reg_write = id_reg_write;
      id_ctrl_s.mem_write = id_mem_write;
      id_ctrl_s.mem_read  = id_mem_read;
      if (id_alu_op == ALU_OP_R) begin
         id_dst_s     = id_rd;
         id_alu_src_s = 1'b0;
      end else begin
         id_dst_s     = id_rt;
         id_alu_src_s = 1'b1;
      end
   end

   // Stall request back to decode. A flush discards the decode instruction,
   // so there is nothing to hold in that cycle.
   always_comb begin
      id_stall = id_valid & ~flush & (hazard_s | ~ex_ready);
   end

   // Next-state selection in priority order: flush, back-pressure, load-use
   // bubble, normal load. Flush and bubble only clear valid/control; the data
   // fields are left as they were since nothing downstream qualifies them
   // without ex_valid.
   always_comb begin
      ex_valid_d     = ex_valid_q;
      ex_ctrl_d      = ex_ctrl_q;
      ex_alu_src_d   = ex_alu_src_q;
      ex_dst_d       = ex_dst_q;
      ex_rs_d        = ex_rs_q;
      ex_rt_d        = ex_rt_q;
      ex_rs_data_d   = ex_rs_data_q;
      ex_rt_data_d   = ex_rt_data_q;
      ex_imm_d       = ex_imm_q;
      ex_funct_d     = ex_funct_q;
      bubble_count_d = bubble_count_q;

      if (flush) begin
         ex_valid_d = 1'b0;
         ex_ctrl_d  = CTRL_NONE;
      end else if (!ex_ready) begin
         ex_valid_d = ex_valid_q;
      end else if (hazard_s) begin
         ex_valid_d = 1'b0;
         ex_ctrl_d  = CTRL_NONE;
         if (bubble_count_q != CNT_MAX) begin
            bubble_count_d = bubble_count_q + CNT_ONE;
         end else begin
            bubble_count_d = bubble_count_q;
         end
      end else begin
         ex_valid_d   = id_valid;
         ex_ctrl_d    = gate_ctrl(id_ctrl_s, id_valid);
         ex_alu_src_d = id_alu_src_s;
         ex_dst_d     = id_dst_s;
         ex_rs_d      = id_rs;
         ex_rt_d      = id_rt;
         ex_rs_data_d = id_rs_data;
         ex_rt_data_d = id_rt_data;
         ex_imm_d     = id_imm;
         ex_funct_d   = id_funct;
      end
   end

   // EX register bank with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q     <= 1'b0;
         ex_ctrl_q      <= CTRL_NONE;
         ex_alu_src_q   <= 1'b0;
         ex_dst_q       <= {REG_W{1'b0}};
         ex_rs_q        <= {REG_W{1'b0}};
         ex_rt_q        <= {REG_W{1'b0}};
         ex_rs_data_q   <= {DATA_W{1'b0}};
         ex_rt_data_q   <= {DATA_W{1'b0}};
         ex_imm_q       <= {DATA_W{1'b0}};
         ex_funct_q     <= 6'b000000;
         bubble_count_q <= {CNT_W{1'b0}};
      end else begin
         ex_valid_q     <= ex_valid_d;
         ex_ctrl_q      <= ex_ctrl_d;
         ex_alu_src_q   <= ex_alu_src_d;
         ex_dst_q       <= ex_dst_d;
         ex_rs_q        <= ex_rs_d;
         ex_rt_q        <= ex_rt_d;
         ex_rs_data_q   <= ex_rs_data_d;
         ex_rt_data_q   <= ex_rt_data_d;
         ex_imm_q       <= ex_imm_d;
         ex_funct_q     <= ex_funct_d;
         bubble_count_q <= bubble_count_d;
      end
   end

   // Output mapping; all EX-side outputs come straight from flops.
   always_comb begin
      ex_valid     = ex_valid_q;
      ex_alu_op    = ex_ctrl_q.alu_op;
      ex_reg_write = ex_ctrl_q.reg_write;
      ex_mem_write = ex_ctrl_q.mem_write;
      ex_mem_read  = ex_ctrl_q.mem_read;
      ex_alu_src   = ex_alu_src_q;
      ex_dst       = ex_dst_q;
      ex_rs        = ex_rs_q;
      ex_rt        = ex_rt_q;
      ex_rs_data   = ex_rs_data_q;
      ex_rt_data   = ex_rt_data_q;
      ex_imm       = ex_imm_q;
      ex_funct     = ex_funct_q;
      bubble_count = bubble_count_q;
   end

endmodule : id_ex_stage

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage
// Directed bench for id_ex_stage. Inputs change 1 time unit after a rising
// edge; outputs are checked after that, well clear of the next edge.
// The counter is instantiated 8 bits wide so saturation is reached quickly;
// the saturation logic does not depend on the width.
// ----------------------------------------------------------------------------
module tb_id_ex_stage;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;
   localparam int CNT_W  = 8;

   logic              clk;
   logic              rst_n;
   logic              id_valid;
   logic [1:0]        id_alu_op;
   logic              id_reg_write, id_mem_write, id_mem_read;
   logic [REG_W-1:0]  id_rs, id_rt, id_rd;
   logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
   logic [5:0]        id_funct;
   logic              flush, ex_ready;
   logic              id_stall, ex_valid;
   logic [1:0]        ex_alu_op;
   logic              ex_reg_write, ex_mem_write, ex_mem_read, ex_alu_src;
   logic [REG_W-1:0]  ex_dst, ex_rs, ex_rt;
   logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm;
   logic [5:0]        ex_funct;
   logic [CNT_W-1:0]  bubble_count;

   int checks = 0;
   int errors = 0;

   id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_alu_op(id_alu_op),
      .id_reg_write(id_reg_write), .id_mem_write(id_mem_write), .id_mem_read(id_mem_read),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_funct(id_funct),
      .flush(flush), .ex_ready(ex_ready), .id_stall(id_stall), .ex_valid(ex_valid),
      .ex_alu_op(ex_alu_op), .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write),
      .ex_mem_read(ex_mem_read), .ex_alu_src(ex_alu_src), .ex_dst(ex_dst),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
      .ex_imm(ex_imm), .ex_funct(ex_funct), .bubble_count(bubble_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction on the decode side, then let combinational
   // outputs settle.
   task automatic drive(input logic v, input logic [1:0] op, input logic rw,
                        input logic mw, input logic mr, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] imm);
      id_valid     = v;
      id_alu_op    = op;
      id_reg_write = rw;
      id_mem_write = mw;
      id_mem_read  = mr;
      id_rs        = rs;
      id_rt        = rt;
      id_rd        = rd;
      id_rs_data   = 32'hA000_0000 | {27'd0, rs};
      id_rt_data   = 32'hB000_0000 | {27'd0, rt};
      id_imm       = imm;
      id_funct     = {1'b1, rd};
      #1;
   endtask

   initial begin
      rst_n    = 1'b0;
      flush    = 1'b0;
      ex_ready = 1'b1;
      drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
      chk("reset_valid", {31'd0, ex_valid}, 32'd0);
      chk("reset_count", {24'd0, bubble_count}, 32'd0);
      chk("reset_stall", {31'd0, id_stall}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("idle_valid", {31'd0, ex_valid}, 32'd0);

      // ---- independent stream: R-type then ORI-class ----
      drive(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 5'd1, 5'd4, 5'd3, 32'h10);
      chk("rtype_stall", {31'd0, id_stall}, 32'd0);
      tick();
      chk("rtype_valid", {31'd0, ex_valid}, 32'd1);
      chk("rtype_dst", {27'd0, ex_dst}, 32'd3);
      chk("rtype_alusrc", {31'd0, ex_alu_src}, 32'd0);
      chk("rtype_rw", {31'd0, ex_reg_write}, 32'd1);
      chk("rtype_aluop", {30'd0, ex_alu_op}, 32'd2);
      chk("rtype_rsdata", ex_rs_data, 32'hA000_0001);
      chk("rtype_rtdata", ex_rt_data, 32'hB000_0004);
      chk("rtype_funct", {26'd0, ex_funct}, 32'h23);
      drive(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 5'd1, 5'd5, 5'd9, 32'h1234);
      chk("ori_stall", {31'd0, id_stall}, 32'd0);
      tick();
      chk("ori_dst", {27'd0, ex_dst}, 32'd5);
      chk("ori_alusrc", {31'd0, ex_alu_src}, 32'd1);
      chk("ori_imm", ex_imm, 32'h1234);
      chk("ori_aluop", {30'd0, ex_alu_op}, 32'd0);

      // ---- load-use on rs ----
      drive(1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 5'd0, 32'h4);
      chk("lw_stall", {31'd0, id_stall}, 32'd0);
      tick();
      chk("lw_memread", {31'd0, ex_mem_read}, 32'd1);
      chk("lw_dst", {27'd0, ex_dst}, 32'd2);
      drive(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 5'd2, 5'd6, 5'd8, 32'h0);
      chk("lu_stall", {31'd0, id_stall}, 32'd1);
      tick();
      chk("bubble_valid", {31'd0, ex_valid}, 32'd0);
      chk("bubble_rw", {31'd0, ex_reg_write}, 32'd0);
      chk("bubble_mr", {31'd0, ex_mem_read}, 32'd0);
      chk("bubble_dst_hold", {27'd0, ex_dst}, 32'd2);
      chk("bubble_count1", {24'd0, bubble_count}, 32'd1);
      chk("lu_stall_clear", {31'd0, id_stall}, 32'd0);
      tick();
      chk("lu_cons_valid", {31'd0, ex_valid}, 32'd1);
      chk("lu_cons_dst", {27'd0, ex_dst}, 32'd8);
      chk("lu_count_keep", {24'd0, bubble_count}, 32'd1);

      // ---- load to r0: no dependency ----
      drive(1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 5'd1, 5'd0, 5'd0, 32'h8);
      tick();
      drive(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd11, 32'h0);
      chk("r0_stall", {31'd0, id_stall}, 32'd0);
      tick();
      chk("r0_dst", {27'd0, ex_dst}, 32'd11);

      // ---- load-use on rt through a store ----
      drive(1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 5'd1, 5'd7, 5'd0, 32'hC);
      tick();
      drive(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 5'd1, 5'd7, 5'd0, 32'h10);
      chk("sw_stall", {31'd0, id_stall}, 32'd1);
      tick();
      chk("sw_bubble_valid", {31'd0, ex_valid}, 32'd0);
      chk("sw_count2", {24'd0, bubble_count}, 32'd2);
      tick();
      chk("sw_memwrite", {31'd0, ex_mem_write}, 32'd1);
      chk("sw_valid", {31'd0, ex_valid}, 32'd1);

      // ---- ORI-class does not read rt ----
      drive(1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 5'd1, 5'd7, 5'd0, 32'h14);
      tick();
      drive(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 5'd1, 5'd7, 5'd0, 32'h77);
      chk("ori_rt_stall", {31'd0, id_stall}, 32'd0);
      tick();
      chk("ori_rt_dst", {27'd0, ex_dst}, 32'd7);
      chk("ori_rt_mr", {31'd0, ex_mem_read}, 32'd0);

      // ---- back-pressure for 3 cycles, then flush under back-pressure ----
      ex_ready = 1'b0;
      drive(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd10, 32'h0);
      for (int i = 0; i < 3; i++) begin
         chk("bp_stall", {31'd0, id_stall}, 32'd1);
         tick();
         chk("bp_valid", {31'd0, ex_valid}, 32'd1);
         chk("bp_dst", {27'd0, ex_dst}, 32'd7);
         chk("bp_imm", ex_imm, 32'h77);
      end
      flush = 1'b1;
      #1;
      chk("flush_bp_stall", {31'd0, id_stall}, 32'd0);
      tick();
      chk("flush_bp_valid", {31'd0, ex_valid}, 32'd0);
      chk("flush_bp_rw", {31'd0, ex_reg_write}, 32'd0);
      chk("flush_bp_dst_hold", {27'd0, ex_dst}, 32'd7);
      flush    = 1'b0;
      ex_ready = 1'b1;

      // ---- hazard held by back-pressure: no bubble until ready ----
      drive(1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 5'd0, 32'h18);
      tick();
      ex_ready = 1'b0;
      drive(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 5'd2, 5'd3, 5'd12, 32'h0);
      chk("bph_stall", {31'd0, id_stall}, 32'd1);
      tick();
      chk("bph_valid", {31'd0, ex_valid}, 32'd1);
      chk("bph_mr", {31'd0, ex_mem_read}, 32'd1);
      chk("bph_count", {24'd0, bubble_count}, 32'd2);
      chk("bph_stall2", {31'd0, id_stall}, 32'd1);
      ex_ready = 1'b1;
      #1;
      tick();
      chk("bph_bubble", {31'd0, ex_valid}, 32'd0);
      chk("bph_count3", {24'd0, bubble_count}, 32'd3);

      // ---- flush together with hazard ----
      drive(1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 5'd0, 32'h1C);
      tick();
      flush = 1'b1;
      drive(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 5'd2, 5'd3, 5'd13, 32'h0);
      chk("fh_stall", {31'd0, id_stall}, 32'd0);
      tick();
      chk("fh_valid", {31'd0, ex_valid}, 32'd0);
      chk("fh_count", {24'd0, bubble_count}, 32'd3);
      flush = 1'b0;

      // ---- counter saturation: 3 + 260 bubbles exceed 8'hFF ----
      for (int i = 0; i < 260; i++) begin
         drive(1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 5'd0, 32'h20);
         tick();
         drive(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 5'd2, 5'd3, 5'd14, 32'h0);
         tick();
         if (i == 100) begin
            chk("sat_mid", {24'd0, bubble_count}, 32'd104);
         end
      end
      chk("sat_count", {24'd0, bubble_count}, 32'hFF);
      chk("sat_valid", {31'd0, ex_valid}, 32'd0);

      // ---- asynchronous reset while EX holds a valid instruction ----
      drive(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 5'd9, 5'd10, 5'd15, 32'h55);
      tick();
      chk("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_valid", {31'd0, ex_valid}, 32'd0);
      chk("rst_rw", {31'd0, ex_reg_write}, 32'd0);
      chk("rst_aluop", {30'd0, ex_alu_op}, 32'd0);
      chk("rst_dst", {27'd0, ex_dst}, 32'd0);
      chk("rst_rsdata", ex_rs_data, 32'd0);
      chk("rst_imm", ex_imm, 32'd0);
      chk("rst_count", {24'd0, bubble_count}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("post_rst_load", {27'd0, ex_dst}, 32'd15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_id_ex_stage

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between decode and execute. Captures the decoded control bundle (ALUOp, RegWrite, MemWrite, MemRead), register indices, operands and immediate, then presents them to EX one cycle later. Detects load-use hazards against the instruction already in EX, stalls decode and inserts a bubble. Also handles branch flush and EX back-pressure, and keeps a saturating bubble counter for performance debug.

## Interface
- DATA_W, 32, operand/immediate width
- REG_W, 5, register index width
- CNT_W, 16, bubble counter width

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  decode holds a valid instruction
- id_alu_op  in  2  ALUOp from decode control (10 R-type, 01 mem/imm-arith, 00 other)
- id_reg_write, id_mem_write, id_mem_read  in  1 each  decode control bits
- id_rs, id_rt, id_rd  in  REG_W each  register fields
- id_rs_data, id_rt_data  in  DATA_W each  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_funct  in  6  function field
- flush  in  1  branch redirect from EX; kill the instruction entering EX
- ex_ready  in  1  EX can accept a new instruction this cycle
- id_stall  out  1  combinational; decode/IF must hold their registers
- ex_valid  out  1  EX register holds a real instruction
- ex_alu_op  out  2
- ex_reg_write, ex_mem_write, ex_mem_read  out  1 each
- ex_alu_src  out  1  1 = use immediate
- ex_dst  out  REG_W  destination index
- ex_rs, ex_rt  out  REG_W each  forwarded-compare indices
- ex_rs_data, ex_rt_data, ex_imm  out  DATA_W each
- ex_funct  out  6
- bubble_count  out  CNT_W  bubbles inserted since reset

## Operation
- Decode-side derivations: dst = id_rd if id_alu_op==10, else id_rt. alu_src = (id_alu_op != 10). uses_rt = (id_alu_op==10) | id_mem_write.
- hazard = id_valid & ex_valid & ex_mem_read & (ex_dst != 0) & ((ex_dst==id_rs) | (uses_rt & ex_dst==id_rt)).
- Per-cycle priority at the clock edge:
  1. flush: ex_valid←0, all ex control bits←0, data fields hold.
  2. !ex_ready: every EX register holds.
  3. hazard: bubble. ex_valid←0, control bits←0, data fields hold, bubble_count increments.
  4. else load: ex_valid←id_valid. Control bits are loaded ANDed with id_valid. Data, indices, dst and alu_src are loaded unconditionally.
- id_stall = id_valid & !flush & (hazard | !ex_ready).
- Invariant: ex_reg_write, ex_mem_write and ex_mem_read are never 1 while ex_valid is 0.
- bubble_count saturates at all-ones. It is cleared only by reset. Flush cycles do not count.

## Timing
- Latency: one cycle from id_* to ex_*.
- Load-use stall lasts exactly one cycle when ex_ready stays high. The load advances and the bubble occupies EX, so the hazard clears the next cycle.
- With ex_ready low, a pending hazard persists and id_stall stays high. No bubble is inserted and the counter does not increment until ex_ready rises.
- flush together with hazard: flush wins, id_stall=0, no count.
- flush together with !ex_ready: flush wins. EX is invalidated even under back-pressure.
- Reset (async assert, any cycle, mid-stall included): ex_valid=0, all control outputs 0, ex_alu_op=00, ex_alu_src=0, indices and data 0, bubble_count=0. id_stall reflects inputs combinationally.
- Reset deassertion is synchronised externally. The first load happens on the first edge after release.

## Structure
- Shared package pipe_pkg holds:
  - ALU_OP_R=2'b10, ALU_OP_MEMI=2'b01, ALU_OP_OTHER=2'b00
  - opcode constants OP_RTYPE=6'b000100, OP_IMM0=6'b001100, OP_IMM1=6'b001101, OP_SW=6'b010000, OP_LW=6'b010001
  - a packed ctrl_t struct {alu_op, reg_write, mem_write, mem_read}
- One sub-module, hazard_unit: purely combinational. It computes hazard and uses_rt, and is reused later by the forwarding work.

## Test plan
- Reset mid-stream: assert rst_n=0 while ex_valid=1 → all ex_* outputs 0 and bubble_count=0 immediately, without waiting for a clock.
- Independent stream, R-type (alu_op=10, rd=3, rt=4) then ORI-class (alu_op=00, rt=5) → ex_dst=3 then 5, ex_alu_src=0 then 1, each one cycle after presentation, id_stall never high.
- Load-use: LW (mem_read=1, rt=2), then R-type with rs=2 → id_stall=1 for one cycle, one bubble (ex_valid=0, controls 0), bubble_count=1, R-type reaches EX one cycle later than unstalled.
- Load-use on rt: LW dst=0, then consumer rs=0 → no stall. LW dst=7, then SW with rt=7 → stall. LW dst=7, then ORI-class with rt=7 → no stall.
- Back-pressure and flush: hold ex_ready=0 for 3 cycles → EX outputs frozen and id_stall=1. Assert flush with ex_ready=0 → ex_valid=0 next edge.
- Counter saturation: preload via 65,536 forced hazards → bubble_count stays 0xFFFF.
